// File: rtl/card_shoe.sv
// card_shoe: one 52-card deck held in registers, Fisher-Yates shuffled from a free-running LFSR,
//   dealt one card per draw request with no repeats until the next shuffle.
// Ports: clk_i/rst_ni (async active-low); draw_req_i, shuffle_req_i single-cycle request pulses;
//   card_valid_o pulse with card_value_o (1..10) / card_rank_o (1..13) held until the next card;
//   cards_left_o undealt count; busy_o high while building or shuffling; draw_err_o refusal pulse.
// Option: define AUTO_RESHUFFLE_EN to reshuffle automatically once cards_left <= CUT_CARD.
// Latency: draw_req in cycle n -> card_valid in cycle n+1; back-to-back draws are accepted.
module card_shoe #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [5:0]  CUT_CARD  = 6'd0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       draw_req_i,
  input  logic       shuffle_req_i,
  output logic       card_valid_o,
  output logic [3:0] card_value_o,
  output logic [3:0] card_rank_o,
  output logic [5:0] cards_left_o,
  output logic       busy_o,
  output logic       draw_err_o
);

`ifdef AUTO_RESHUFFLE_EN
  localparam logic AUTO_EN = 1'b1;
`else
  localparam logic AUTO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_INIT, S_SHUFFLE, S_READY} state_t;

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [5:0]  ptr_q;        // INIT: entry being written; READY: index of the top card
  logic [5:0]  i_q;          // Fisher-Yates position, 51 down to 1
  logic [3:0]  init_rank_q;  // rank written during INIT, wraps 13 -> 1
  logic        auto_pend_q;  // served draw reached the cut card; reshuffle next cycle
  logic        card_valid_q;
  logic [3:0]  card_value_q;
  logic [3:0]  card_rank_q;
  logic [5:0]  cards_left_q;
  logic        busy_q;
  logic        draw_err_q;
  logic [3:0]  deck_q [52];

  logic [5:0]  j;
  logic        j_ok;
  logic        lfsr_fb;
  logic [3:0]  top_card;

  assign j        = lfsr_q[5:0];
  assign j_ok     = (j <= i_q);  // rejection sampling keeps j uniform over 0..i
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3];
  assign top_card = deck_q[ptr_q];

  // Free-running in every state: draw/shuffle timing from the player supplies the entropy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  // Deck storage needs no reset: INIT rewrites every entry after each reset.
  always_ff @(posedge clk_i) begin
    case (state_q)
      S_INIT: deck_q[ptr_q] <= init_rank_q;
      S_SHUFFLE: begin
        if (j_ok) begin
          deck_q[i_q] <= deck_q[j];
          deck_q[j]   <= deck_q[i_q];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_INIT;
      ptr_q        <= 6'd0;
      i_q          <= 6'd51;
      init_rank_q  <= 4'd1;
      auto_pend_q  <= 1'b0;
      card_valid_q <= 1'b0;
      card_value_q <= 4'd0;
      card_rank_q  <= 4'd0;
      cards_left_q <= 6'd0;
      busy_q       <= 1'b1;
      draw_err_q   <= 1'b0;
    end else begin
      card_valid_q <= 1'b0;
      draw_err_q   <= 1'b0;
      case (state_q)
        S_INIT: begin
          draw_err_q  <= draw_req_i;
          init_rank_q <= (init_rank_q == 4'd13) ? 4'd1 : init_rank_q + 4'd1;
          if (ptr_q == 6'd51) begin
            ptr_q   <= 6'd0;
            i_q     <= 6'd51;
            state_q <= S_SHUFFLE;
          end else begin
            ptr_q <= ptr_q + 6'd1;
          end
        end
        S_SHUFFLE: begin
          draw_err_q <= draw_req_i;
          if (j_ok) begin
            if (i_q == 6'd1) begin
              ptr_q        <= 6'd0;
              cards_left_q <= 6'd52;
              busy_q       <= 1'b0;
              state_q      <= S_READY;
            end else begin
              i_q <= i_q - 6'd1;
            end
          end
        end
        S_READY: begin
          // The deck is always a permutation, so a reshuffle skips INIT.
          if (shuffle_req_i || auto_pend_q) begin
            draw_err_q  <= draw_req_i;
            auto_pend_q <= 1'b0;
            ptr_q       <= 6'd0;
            i_q         <= 6'd51;
            busy_q      <= 1'b1;
            state_q     <= S_SHUFFLE;
          end else if (draw_req_i) begin
            if (ptr_q < 6'd52) begin
              card_rank_q  <= top_card;
              card_value_q <= (top_card > 4'd10) ? 4'd10 : top_card;
              card_valid_q <= 1'b1;
              ptr_q        <= ptr_q + 6'd1;
              cards_left_q <= cards_left_q - 6'd1;
              auto_pend_q  <= AUTO_EN && ((cards_left_q - 6'd1) <= CUT_CARD);
            end else begin
              draw_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign card_valid_o = card_valid_q;
  assign card_value_o = card_value_q;
  assign card_rank_o  = card_rank_q;
  assign cards_left_o = cards_left_q;
  assign busy_o       = busy_q;
  assign draw_err_o   = draw_err_q;

endmodule

// File: tb/tb_card_shoe.sv
module tb_card_shoe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       draw_req;
  logic       shuffle_req;
  logic       card_valid;
  logic [3:0] card_value;
  logic [3:0] card_rank;
  logic [5:0] cards_left;
  logic       busy;
  logic       draw_err;

  always #5 clk = ~clk;

`ifdef AUTO_RESHUFFLE_EN
  card_shoe #(.CUT_CARD(6'd10)) dut (
`else
  card_shoe dut (
`endif
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .draw_req_i   (draw_req),
    .shuffle_req_i(shuffle_req),
    .card_valid_o (card_valid),
    .card_value_o (card_value),
    .card_rank_o  (card_rank),
    .cards_left_o (cards_left),
    .busy_o       (busy),
    .draw_err_o   (draw_err)
  );

  int checks = 0;
  int errors = 0;
  int sb[$];          // expected cards_left per outstanding draw
  int model_left;
  int rank_cnt[16];
  int v10_cnt;
  int ready_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      cyc();
      n++;
    end
    chk("ready_within_2000", busy, 1'b0);
  endtask

  task automatic check_reset_vals();
    chk("rst_card_valid", card_valid, 1'b0);
    chk("rst_card_value", card_value, 4'd0);
    chk("rst_card_rank", card_rank, 4'd0);
    chk("rst_cards_left", cards_left, 6'd0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_draw_err", draw_err, 1'b0);
  endtask

  task automatic draw_one();
    int exp_left;
    logic [3:0] exp_val;
    draw_req = 1'b1;
    sb.push_back(model_left - 1);
    model_left--;
    cyc();
    draw_req = 1'b0;
    chk("valid_next_cycle", card_valid, 1'b1);
    chk("no_err_on_draw", draw_err, 1'b0);
    if (card_valid === 1'b1 && sb.size() > 0) begin
      exp_left = sb.pop_front();
      chk("cards_left_after_draw", cards_left, exp_left);
    end
    chk("rank_in_range", (card_rank >= 4'd1 && card_rank <= 4'd13), 1'b1);
    exp_val = (card_rank > 4'd10) ? 4'd10 : card_rank;
    chk("value_from_rank", card_value, exp_val);
    if (card_rank <= 4'd13) rank_cnt[card_rank]++;
    if (card_value == 4'd10) v10_cnt++;
    cyc();
    chk("valid_one_cycle", card_valid, 1'b0);
    cyc();
  endtask

  task automatic deal_full_pass();
    for (int r = 0; r < 16; r++) rank_cnt[r] = 0;
    v10_cnt = 0;
    for (int k = 0; k < 52; k++) draw_one();
    for (int r = 1; r <= 13; r++) chk($sformatf("rank_%0d_count", r), rank_cnt[r], 4);
    chk("value10_count", v10_cnt, 16);
    chk("empty_after_pass", cards_left, 6'd0);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic refused_draw(input string tag);
    logic [3:0] held_val;
    logic [3:0] held_rank;
    held_val  = card_value;
    held_rank = card_rank;
    draw_req = 1'b1;
    cyc();
    draw_req = 1'b0;
    chk({tag, "_err"}, draw_err, 1'b1);
    chk({tag, "_no_valid"}, card_valid, 1'b0);
    chk({tag, "_value_held"}, card_value, held_val);
    chk({tag, "_rank_held"}, card_rank, held_rank);
    cyc();
    chk({tag, "_err_one_cycle"}, draw_err, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    draw_req    = 1'b0;
    shuffle_req = 1'b0;
    cyc();
    cyc();
    check_reset_vals();

    // Reset release: INIT (52) plus at least 51 accepted swaps before busy falls.
    rst_n = 1'b1;
    wait_ready(ready_cycles);
    chk("init_shuffle_min_cycles", (ready_cycles >= 103), 1'b1);
    chk("full_shoe", cards_left, 6'd52);
    chk("idle_no_valid", card_valid, 1'b0);
    model_left = 52;

`ifndef AUTO_RESHUFFLE_EN
    deal_full_pass();

    // Empty shoe refuses the 53rd draw.
    refused_draw("empty_draw");
    chk("empty_stays_empty", cards_left, 6'd0);

    shuffle_req = 1'b1;
    cyc();
    shuffle_req = 1'b0;
    chk("shuffle_sets_busy", busy, 1'b1);
    refused_draw("busy_draw");
    wait_ready(ready_cycles);
    chk("reshuffle_min_cycles", (ready_cycles >= 50), 1'b1);
    chk("refill_after_shuffle", cards_left, 6'd52);
    model_left = 52;

    // Shuffle wins over a simultaneous draw.
    draw_one();
    draw_one();
    draw_req    = 1'b1;
    shuffle_req = 1'b1;
    cyc();
    draw_req    = 1'b0;
    shuffle_req = 1'b0;
    chk("combo_err", draw_err, 1'b1);
    chk("combo_no_valid", card_valid, 1'b0);
    chk("combo_busy", busy, 1'b1);
    chk("combo_left_held", cards_left, 6'd50);
    wait_ready(ready_cycles);
    chk("combo_refill", cards_left, 6'd52);

    // Reset in the middle of a shuffle.
    shuffle_req = 1'b1;
    cyc();
    shuffle_req = 1'b0;
    repeat (20) cyc();
    chk("mid_shuffle_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    cyc();
    cyc();
    rst_n = 1'b1;
    wait_ready(ready_cycles);
    chk("reinit_min_cycles", (ready_cycles >= 103), 1'b1);
    chk("reinit_full_shoe", cards_left, 6'd52);
    model_left = 52;
    deal_full_pass();
`else
    // With the cut card at 10, the 42nd draw triggers the reshuffle.
    for (int k = 0; k < 41; k++) draw_one();
    draw_req = 1'b1;
    cyc();
    draw_req = 1'b0;
    chk("cut_draw_valid", card_valid, 1'b1);
    chk("cut_left", cards_left, 6'd10);
    chk("cut_not_busy_yet", busy, 1'b0);
    cyc();
    chk("cut_busy_next", busy, 1'b1);
    wait_ready(ready_cycles);
    chk("cut_refill", cards_left, 6'd52);
    sb.delete();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
